// File: rtl/bus_cycle_gen_if.sv
// bus_cycle_gen_if: request/response port plus 8088-style bus pins.
// master is the cycle generator side; slave is the requester/peripheral side.
interface bus_cycle_gen_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_write;
    logic              req_io;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              ALE;
    logic              RD_N;
    logic              WR_N;
    logic              IOM;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DATA_OE;
    logic [DATA_W-1:0] DATA_IN;
    logic              READY;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_io, DATA_IN, READY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ALE, RD_N, WR_N, IOM, ADDRESS, DATA_OUT, DATA_OE
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_io, DATA_IN, READY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ALE, RD_N, WR_N, IOM, ADDRESS, DATA_OUT, DATA_OE
    );
endinterface

// File: rtl/bus_cycle_gen.sv
// bus_cycle_gen: turns single-beat valid/ready requests into T1-T4 bus cycles.
// Define WAIT_TIMEOUT_EN to abort wait states after MAX_WAIT TW cycles with rsp_err.
module bus_cycle_gen #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input logic             CLK,
    input logic             RESET_N,
    bus_cycle_gen_if.master bus
);
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } state_t;

    state_t            r_state, w_next;
    logic              r_write, r_ale, r_rd_n, r_wr_n, r_iom, r_data_oe, r_rsp_valid, r_rsp_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              w_req_ready, w_accept, w_wait_phase, w_timeout, w_strobe;

    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("MAX_WAIT must be at least 1");
    end

    assign w_req_ready  = RESET_N && (r_state == IDLE || r_state == T4);
    assign w_accept     = w_req_ready && bus.req_valid;
    assign w_wait_phase = r_state == T3 || r_state == TW;

`ifdef WAIT_TIMEOUT_EN
    localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
    logic [CW-1:0] r_wait_cnt;
    always_ff @(posedge CLK) begin
        if (!RESET_N || r_state == T1) r_wait_cnt <= '0;
        else if (r_state == TW) r_wait_cnt <= r_wait_cnt + 1'b1;
    end
    // r_wait_cnt counts earlier TW cycles, so this fires at the end of the MAX_WAIT-th one
    assign w_timeout = r_state == TW && !bus.READY && r_wait_cnt == CW'(MAX_WAIT - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = IDLE;
        if (w_accept) w_next = T1;
        else if (r_state == T1) w_next = T2;
        else if (r_state == T2) w_next = T3;
        else if (w_wait_phase) w_next = (bus.READY || w_timeout) ? T4 : TW;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Bus pins are registered from the next state so they change cleanly on the edge
    assign w_strobe = w_next == T2 || w_next == T3 || w_next == TW;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_ale       <= 1'b0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_addr      <= '0;
            r_iom       <= 1'b0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_ale       <= w_next == T1;
            r_rd_n      <= !(w_strobe && !r_write);
            r_wr_n      <= !(w_strobe && r_write);
            r_data_oe   <= w_strobe && r_write;
            r_rsp_valid <= w_next == T4;
            r_rsp_err   <= w_timeout;
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_iom   <= bus.req_io;
                r_wdata <= bus.req_wdata;
                r_write <= bus.req_write;
            end
            if (w_wait_phase && bus.READY && !r_write) r_rdata <= bus.DATA_IN;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ALE       = r_ale;
    assign bus.RD_N      = r_rd_n;
    assign bus.WR_N      = r_wr_n;
    assign bus.IOM       = r_iom;
    assign bus.ADDRESS   = r_addr;
    assign bus.DATA_OUT  = r_wdata;
    assign bus.DATA_OE   = r_data_oe;
endmodule

// File: tb/tb_bus_cycle_gen.sv
// tb_bus_cycle_gen: random requests and wait states checked cycle by cycle
// against a transaction-level model of the T1..T4 sequence.
module tb_bus_cycle_gen;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int MW = 4;
`ifdef WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_cycle_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_cycle_gen #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // directed opening sequence, issued back to back
    logic [AW-1:0] d_addr  [6] = '{20'h12345, 20'h00080, 20'h01000, 20'h00010, 20'h00020, 20'h0ABCD};
    logic [DW-1:0] d_wdata [6] = '{8'h00, 8'h3C, 8'h00, 8'h00, 8'h77, 8'h00};
    logic          d_write [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic          d_io    [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int            d_wait  [6] = '{0, 0, 3, 0, 0, 100};
    logic [DW-1:0] d_rdata [6] = '{8'hA5, 8'h00, 8'h5A, 8'hC3, 8'h00, 8'hE1};

    // model: transaction in flight occupies cycles k = 0 (T1) .. len-1 (T4)
    bit            busy, t_write, t_io, t_err, dout_zero, did_rst, acc, t1, stb, t4;
    int            k, len, ready_at, n_acc, nw;
    logic [AW-1:0] t_addr, e_addr;
    logic [DW-1:0] t_wdata, t_rdata, e_rdata;
    logic          e_iom;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_write = 1'b0;
        bus.req_io    = 1'b0;
        bus.READY     = 1'b0;
        bus.DATA_IN   = '0;
        busy = 0; dout_zero = 1; did_rst = 0; n_acc = 0; k = 0; len = 4; ready_at = 2;
        t_write = 0; t_io = 0; t_err = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
        e_addr = '0; e_iom = 1'b0; e_rdata = '0;
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            t1  = busy && k == 0;
            stb = busy && k >= 1 && k <= len - 2;
            t4  = busy && k == len - 1;
            check("req_ready", bus.req_ready, rst_n && (!busy || t4));
            check("ALE", bus.ALE, t1);
            check("RD_N", bus.RD_N, !(stb && !t_write));
            check("WR_N", bus.WR_N, !(stb && t_write));
            check("DATA_OE", bus.DATA_OE, stb && t_write);
            check("rsp_valid", bus.rsp_valid, t4);
            check("rsp_err", bus.rsp_err, t4 && t_err);
            check("ADDRESS", bus.ADDRESS, e_addr);
            check("IOM", bus.IOM, e_iom);
            check("rsp_rdata", bus.rsp_rdata, e_rdata);
            if (stb && t_write) check("DATA_OUT", bus.DATA_OUT, t_wdata);
            if (dout_zero) check("DATA_OUT_rst", bus.DATA_OUT, 0);
            rst_n = 1'b1;
            if (n_acc >= 6 && busy && t_write && k == 1 && !did_rst) begin
                rst_n = 1'b0;
                did_rst = 1;
            end else if (cyc > 0 && $urandom_range(0, 199) == 0) rst_n = 1'b0;
            if (n_acc < 6) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = d_addr[n_acc];
                bus.req_wdata = d_wdata[n_acc];
                bus.req_write = d_write[n_acc];
                bus.req_io    = d_io[n_acc];
            end else begin
                bus.req_valid = $urandom_range(0, 2) != 0;
                bus.req_addr  = AW'($urandom);
                bus.req_wdata = DW'($urandom);
                bus.req_write = 1'($urandom);
                bus.req_io    = 1'($urandom);
            end
            bus.READY   = (busy && k >= 2 && k <= len - 2) ? (k == ready_at) : 1'($urandom);
            bus.DATA_IN = (busy && !t_write && k == ready_at) ? t_rdata : DW'($urandom);
            if (!rst_n) begin
                busy = 0; e_addr = '0; e_iom = 1'b0; e_rdata = '0; dout_zero = 1;
            end else begin
                acc = bus.req_valid && (!busy || t4);
                if (busy) begin
                    if (!t_write && k == ready_at) e_rdata = t_rdata;
                    if (t4) busy = 0;
                    else k++;
                end
                if (acc) begin
                    nw = (n_acc < 6) ? d_wait[n_acc] :
                         ($urandom_range(0, 19) == 0) ? 100 : int'($urandom_range(0, 3));
                    busy = 1; k = 0;
                    t_addr = bus.req_addr; t_wdata = bus.req_wdata;
                    t_write = bus.req_write; t_io = bus.req_io;
                    t_rdata = (n_acc < 6) ? d_rdata[n_acc] : DW'($urandom);
                    ready_at = 2 + nw;
                    t_err = TO_EN && nw > MW;
                    len = t_err ? 4 + MW : 4 + nw;
                    e_addr = t_addr; e_iom = t_io; dout_zero = 0;
                    n_acc++;
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
